// File: rtl/video_timing_analyzer.sv
// Measures per-frame horizontal/vertical timing of a captured sync/DE/RGB stream,
// flags stable timing and reports the first white active pixel of each frame.
module video_timing_analyzer #(
   parameter int         CNT_W      = 11,
   parameter logic [7:0] LUMA_THOLD = 8'h80,
   parameter int         H_TIMEOUT  = 2047
) (
   input  logic             clk27,
   input  logic             reset_n,
   input  logic             HSYNC_in,
   input  logic             VSYNC_in,
   input  logic             ENABLE_in,
   input  logic [7:0]       R_in,
   input  logic [7:0]       G_in,
   input  logic [7:0]       B_in,
   output logic [CNT_W-1:0] h_total,
   output logic [CNT_W-1:0] h_synclen,
   output logic [CNT_W-1:0] h_backporch,
   output logic [CNT_W-1:0] h_active,
   output logic [CNT_W-1:0] v_total,
   output logic [CNT_W-1:0] v_synclen,
   output logic [CNT_W-1:0] v_backporch,
   output logic [CNT_W-1:0] v_active,
   output logic             frame_start,
   output logic             timing_valid,
   output logic             white_detected,
   output logic [CNT_W-1:0] white_line
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] H_LIMIT = CNT_W'(H_TIMEOUT);

   // IDLE: disarmed; ARMED: commits but has no trusted reference; TRACK: reference valid
   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_TRACK} state_t;
   state_t state, state_next;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
      return (a > b) ? a - b : '0;
   endfunction

   logic             hsync_q, vsync_q, de_q, hsync_d, de_d, vsync_smp;
   logic [7:0]       r_q, g_q, b_q;
   logic [CNT_W-1:0] hc_q, vc_q, hc, vc;
   logic             line_start, hs_rise, de_rise, frame_hit, loss, pix_white, commit;

   logic [CNT_W-1:0] ln_sync, ln_bp, ln_active, ln_sync_n, ln_bp_n, ln_active_n;
   logic             ln_sync_seen, ln_bp_seen, ln_sync_seen_n, ln_bp_seen_n, first_de_clk;

   logic             w_h_set, w_mismatch, w_h_set_n, w_mismatch_n;
   logic [CNT_W-1:0] w_h_total, w_h_sync, w_h_bp, w_h_active;
   logic [CNT_W-1:0] w_h_total_n, w_h_sync_n, w_h_bp_n, w_h_active_n;
   logic [CNT_W-1:0] w_vsync, w_vbp, w_vact, w_white_line;
   logic [CNT_W-1:0] w_vsync_n, w_vbp_n, w_vact_n, w_white_line_n;
   logic             w_de_seen, w_white, w_de_seen_n, w_white_n;

   logic             ended_de, take_line, f_mismatch, same_set;
   logic [CNT_W-1:0] f_h_total, f_h_sync, f_h_bp, f_h_active, f_v_total;

   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         hsync_q   <= 1'b1;
         vsync_q   <= 1'b1;
         de_q      <= 1'b0;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
         hsync_d   <= 1'b1;
         de_d      <= 1'b0;
         vsync_smp <= 1'b1;
         hc_q      <= '0;
         vc_q      <= '0;
      end else begin
         hsync_q   <= HSYNC_in;
         vsync_q   <= VSYNC_in;
         de_q      <= ENABLE_in;
         r_q       <= R_in;
         g_q       <= G_in;
         b_q       <= B_in;
         hsync_d   <= hsync_q;
         de_d      <= de_q;
         if (line_start) vsync_smp <= vsync_q;
         hc_q      <= sat_inc(hc);
         vc_q      <= vc;
      end
   end

   // hc/vc are the counts of the current clock; the line-start clock is always hc=0
   assign line_start = hsync_d & ~hsync_q;
   assign hs_rise    = hsync_q & ~hsync_d;
   assign de_rise    = de_q & ~de_d;
   assign frame_hit  = line_start & ~vsync_q & vsync_smp;
   assign hc         = line_start ? '0 : hc_q;
   assign vc         = frame_hit ? '0 : (line_start ? sat_inc(vc_q) : vc_q);
   assign loss       = (hc == H_LIMIT) || (vc == CNT_MAX);
   assign pix_white  = de_q && (r_q >= LUMA_THOLD) && (g_q >= LUMA_THOLD) && (b_q >= LUMA_THOLD);
   assign commit     = frame_hit && (state != ST_IDLE) && !loss;

   always_comb begin
      ln_sync_n      = line_start ? '0 : ln_sync;
      ln_sync_seen_n = ~line_start & ln_sync_seen;
      ln_bp_n        = line_start ? '0 : ln_bp;
      ln_bp_seen_n   = ~line_start & ln_bp_seen;
      ln_active_n    = line_start ? '0 : ln_active;
      first_de_clk   = de_q && (ln_active_n == '0);
      if (hs_rise && !ln_sync_seen_n) begin
         ln_sync_n      = hc;
         ln_sync_seen_n = 1'b1;
      end
      if (de_rise && !ln_bp_seen_n) begin
         ln_bp_n      = sat_sub(hc, ln_sync_n);
         ln_bp_seen_n = 1'b1;
      end
      if (de_q) ln_active_n = sat_inc(ln_active_n);
   end

   // The line that ends at a line start is folded in before any commit uses it
   assign ended_de   = (ln_active != '0);
   assign take_line  = ended_de & ~w_h_set;
   assign f_h_total  = take_line ? hc_q : w_h_total;
   assign f_h_sync   = take_line ? ln_sync : w_h_sync;
   assign f_h_bp     = take_line ? ln_bp : w_h_bp;
   assign f_h_active = take_line ? ln_active : w_h_active;
   assign f_mismatch = w_mismatch | (w_h_set & (hc_q != w_h_total));
   assign f_v_total  = sat_inc(vc_q);

   always_comb begin
      w_h_set_n      = w_h_set;
      w_h_total_n    = w_h_total;
      w_h_sync_n     = w_h_sync;
      w_h_bp_n       = w_h_bp;
      w_h_active_n   = w_h_active;
      w_mismatch_n   = w_mismatch;
      if (frame_hit) begin
         w_h_set_n    = 1'b0;
         w_h_total_n  = '0;
         w_h_sync_n   = '0;
         w_h_bp_n     = '0;
         w_h_active_n = '0;
         w_mismatch_n = 1'b0;
      end else if (line_start) begin
         w_h_set_n    = w_h_set | ended_de;
         w_h_total_n  = f_h_total;
         w_h_sync_n   = f_h_sync;
         w_h_bp_n     = f_h_bp;
         w_h_active_n = f_h_active;
         w_mismatch_n = f_mismatch;
      end
      w_vsync_n      = frame_hit ? '0 : w_vsync;
      w_vbp_n        = frame_hit ? '0 : w_vbp;
      w_vact_n       = frame_hit ? '0 : w_vact;
      w_de_seen_n    = ~frame_hit & w_de_seen;
      w_white_n      = ~frame_hit & w_white;
      w_white_line_n = frame_hit ? '0 : w_white_line;
      if (line_start && !vsync_q) w_vsync_n = sat_inc(w_vsync_n);
      if (de_q && !w_de_seen_n) begin
         w_de_seen_n = 1'b1;
         w_vbp_n     = sat_sub(vc, w_vsync_n);
      end
      if (first_de_clk) w_vact_n = sat_inc(w_vact_n);
      if (pix_white && !w_white_n) begin
         w_white_n      = 1'b1;
         w_white_line_n = vc;
      end
   end

   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         ln_sync      <= '0;
         ln_sync_seen <= 1'b0;
         ln_bp        <= '0;
         ln_bp_seen   <= 1'b0;
         ln_active    <= '0;
         w_h_set      <= 1'b0;
         w_h_total    <= '0;
         w_h_sync     <= '0;
         w_h_bp       <= '0;
         w_h_active   <= '0;
         w_mismatch   <= 1'b0;
         w_vsync      <= '0;
         w_vbp        <= '0;
         w_vact       <= '0;
         w_de_seen    <= 1'b0;
         w_white      <= 1'b0;
         w_white_line <= '0;
      end else begin
         ln_sync      <= ln_sync_n;
         ln_sync_seen <= ln_sync_seen_n;
         ln_bp        <= ln_bp_n;
         ln_bp_seen   <= ln_bp_seen_n;
         ln_active    <= ln_active_n;
         w_h_set      <= w_h_set_n;
         w_h_total    <= w_h_total_n;
         w_h_sync     <= w_h_sync_n;
         w_h_bp       <= w_h_bp_n;
         w_h_active   <= w_h_active_n;
         w_mismatch   <= w_mismatch_n;
         w_vsync      <= w_vsync_n;
         w_vbp        <= w_vbp_n;
         w_vact       <= w_vact_n;
         w_de_seen    <= w_de_seen_n;
         w_white      <= w_white_n;
         w_white_line <= w_white_line_n;
      end
   end

   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (loss) begin
         state_next = ST_IDLE;
      end else if (frame_hit) begin
         case (state)
            ST_IDLE:  state_next = ST_ARMED;
            default:  state_next = ST_TRACK;
         endcase
      end
   end

   assign same_set = (f_h_total == h_total) && (f_h_sync == h_synclen) &&
                     (f_h_bp == h_backporch) && (f_h_active == h_active) &&
                     (f_v_total == v_total) && (w_vsync == v_synclen) &&
                     (w_vbp == v_backporch) && (w_vact == v_active);

   // Outputs only move at a commit; a lost stream can additionally drop timing_valid
   always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
         h_total        <= '0;
         h_synclen      <= '0;
         h_backporch    <= '0;
         h_active       <= '0;
         v_total        <= '0;
         v_synclen      <= '0;
         v_backporch    <= '0;
         v_active       <= '0;
         frame_start    <= 1'b0;
         timing_valid   <= 1'b0;
         white_detected <= 1'b0;
         white_line     <= '0;
      end else begin
         frame_start <= commit;
         if (commit) begin
            h_total        <= f_h_total;
            h_synclen      <= f_h_sync;
            h_backporch    <= f_h_bp;
            h_active       <= f_h_active;
            v_total        <= f_v_total;
            v_synclen      <= w_vsync;
            v_backporch    <= w_vbp;
            v_active       <= w_vact;
            white_detected <= w_white;
            white_line     <= w_white_line;
            timing_valid   <= (state == ST_TRACK) && same_set && !f_mismatch;
         end else if (loss) begin
            timing_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/video_timing_analyzer.md
# video_timing_analyzer

Receive-side counterpart of the test pattern generator. It samples a parallel video stream (HSYNC, VSYNC, DE, RGB) in the clk27 domain and measures horizontal and vertical timing per frame. It flags when the measured timing is stable, and detects white pixels in the active area for the latency tester. It sits on the loopback/capture path and feeds the status registers read by the CPU.

## Interface
Parameters:
- CNT_W, 11, width of all counters and measurement outputs (saturate at 2^CNT_W-1)
- LUMA_THOLD, 8'h80, a pixel counts as white when R, G and B are all >= this value
- H_TIMEOUT, 2047, clocks without an HSYNC falling edge before the stream is declared lost

Ports:
- clk27 in 1: pixel clock
- reset_n in 1: asynchronous, active-low reset
- HSYNC_in in 1: negative-polarity horizontal sync
- VSYNC_in in 1: negative-polarity vertical sync
- ENABLE_in in 1: data enable (active area)
- R_in, G_in, B_in in 8 each: pixel data
- h_total out CNT_W: clocks per line
- h_synclen out CNT_W: HSYNC low length in clocks
- h_backporch out CNT_W: clocks from HSYNC rise to DE rise
- h_active out CNT_W: DE-high clocks per line
- v_total out CNT_W: lines per frame
- v_synclen out CNT_W: lines with VSYNC low
- v_backporch out CNT_W: lines from end of VSYNC to first DE line
- v_active out CNT_W: lines containing DE
- frame_start out 1: one-clock pulse at each detected frame start
- timing_valid out 1: timing is stable
- white_detected out 1: previous frame contained a white active pixel
- white_line out CNT_W: line index of the first white pixel in the previous frame

## Operation
- Reset values:
  - All inputs pass through one input register stage; its reset value is 1 for the syncs and 0 for DE and RGB.
  - All outputs reset to 0.
  - Internal armed and match flags reset to 0.
- Line start:
  - Line start is a falling edge of the registered HSYNC.
  - The horizontal counter hc is 0 on the line-start clock, then increments and saturates.
- Per-line capture (at hc values, on the registered signals):
  - sync length = hc at the HSYNC rise.
  - backporch = hc at the first DE rise minus sync length.
  - active = count of DE-high clocks.
  - total = hc+1 at the next line start.
- Horizontal working set: taken from the first line of the frame that has DE. If any later line's total differs from it, set line_mismatch.
- VSYNC sampling: registered VSYNC is sampled only at line starts.
- Frame start: a line start where VSYNC is sampled low and the previous sample was high. That line is line 0.
- Vertical counter vc:
  - Increments at each line start and saturates.
  - v_synclen = number of VSYNC-low line samples.
  - first DE line index minus v_synclen = v_backporch.
  - v_active = lines with at least one DE clock.
  - v_total = vc+1 at the next frame start.
- Commit at frame start:
  - The first frame start after reset only arms the block; it does not commit.
  - Each later frame start copies the working set to the outputs and pulses frame_start.
  - It also commits white_detected and white_line, then clears the working set and line_mismatch.
- timing_valid:
  - Set at a commit when the new set equals the previous committed set and line_mismatch was 0.
  - Cleared at a commit otherwise.
- White detect:
  - Applies on any DE-high clock with all channels >= LUMA_THOLD.
  - The first such pixel in a frame latches vc into the working white_line and sets the working flag.
- Stream loss:
  - Triggered when hc reaches H_TIMEOUT, or vc saturates.
  - Action: clear timing_valid and disarm the block. Measurement outputs hold their last values.

## Timing
- Input register adds 1 clock. frame_start and the updated outputs appear 2 clocks after the input HSYNC/VSYNC falling edge.
- All outputs change only at commit, except that timing_valid also drops on stream loss.
- Earliest timing_valid=1 is the third frame start after reset or after a loss.
- When DE rise and HSYNC rise fall on the same clock, backporch = 0.
- When hc saturates, captures use the saturated value.
- Reset mid-frame: everything returns to reset values immediately. The partial frame is discarded by the arming rule.

## Test plan
- 720x480 stream (858 clocks per line, HSYNC low for 62 clocks, DE rises 122 clocks after HSYNC falls, 720 DE clocks, 525 lines, VSYNC low for 6 lines, DE on lines 36-515) -> h_total=858, h_synclen=62, h_backporch=60, h_active=720, v_total=525, v_synclen=6, v_backporch=30, v_active=480; timing_valid=1 at the 3rd frame start.
- Same stream with HSYNC stuck high for 2100 clocks mid-frame -> timing_valid=0 2047 clocks after the last line start; reasserts at the 3rd frame start after HSYNC returns.
- One line of 860 clocks inserted in a stable frame -> timing_valid=0 at that frame's commit and 1 again two frames later.
- White box 0xFF on lines 36-155, columns 122-301, with LUMA_THOLD=0x80 -> white_detected=1, white_line=36 at the next commit. All-0x7F frame -> white_detected=0.
- reset_n pulsed low at line 200 -> all outputs 0 at once; first frame_start pulse appears at the 2nd frame start after release.
- Lines 0-4 carry pixels with R=G=0xFF, B=0x80 outside DE -> no white detection, because detection is gated by DE.
